write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Final pipeline stage, directly downstream of the memory-access stage. Takes its registered result, destination register, write-enable, branch decision, offset and PC. Owns the 32x64 integer register file, with x0 hardwired to zero, and serves the two decode read ports. Turns a taken branch into a one-cycle PC redirect, then a bounded flush window that squashes wrong-path writes; also counts retired instructions.

Parameters:
XLEN, 64, datapath and register width
NREGS, 32, register count (index width 5)
FLUSH_CYCLES, 2, cycles of squash after redirect; legal range 1..7

Ports:
CLK  input  1  clock; all state updates on posedge
RST_N  input  1  synchronous active-low reset, sampled on posedge CLK
instr_valid_i  input  1  an instruction is present in this stage this cycle
rd_i  input  5  destination register index
res_i  input  XLEN  result to write back (load data or ALU result)
write_back_en_i  input  1  instruction writes rd_i
take_branch_i  input  1  instruction is a taken branch
branch_offset_i  input  XLEN  branch offset
PC_i  input  XLEN  PC of the instruction
rs1_addr  input  5  read port 1 index
rs2_addr  input  5  read port 2 index
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
redirect_valid  output  1  one-cycle pulse: fetch loads redirect_pc
redirect_pc  output  XLEN  branch target
flush  output  1  upstream stages squash; high throughout the flush window
retire_count  output  XLEN  count of instructions retired

Behaviour:
- Reset: all registers 0; state IDLE; redirect_valid=0; redirect_pc=0; flush=0; retire_count=0. Reset has priority over every other event, including mid-flush: state returns to IDLE and the flush countdown is abandoned.
- Accept: accept = instr_valid_i && state==IDLE.
- Write: on posedge, if accept && write_back_en_i && rd_i!=0, then regs[rd_i] <= res_i. Writes to x0 are dropped. Reads of x0 always return 0.
- Retire: on accept, retire_count increments by 1, wrapping mod 2^XLEN.
- FSM IDLE:
  - accept && take_branch_i: go to REDIRECT; redirect_pc <= PC_i + branch_offset_i (wraps mod 2^XLEN); redirect_valid <= 1; flush <= 1; counter <= FLUSH_CYCLES.
  - A branch that also has write_back_en_i (link write) performs the write in the same cycle.
- FSM REDIRECT: lasts exactly 1 cycle. redirect_valid <= 0; go to FLUSH.
- FSM FLUSH:
  - flush stays 1. Each cycle the counter decrements.
  - Inputs are squashed: no write, no retire, and take_branch_i is ignored.
  - When counter reaches 1, flush <= 0 and state goes to IDLE.
- Flush timing: flush is high for 1+FLUSH_CYCLES cycles after the accepting edge. The first instruction is accepted on the cycle after flush falls.
- redirect_pc holds its value until the next redirect.
- Latency: write visible at read ports the cycle after the accepting edge (see optional feature). Redirect is 1 cycle after the branch is accepted.
- Back-to-back taken branches: the second arrives during REDIRECT/FLUSH, is squashed and produces no redirect.

Optional Feature:
WB_BYPASS_EN
- Defined: each read port returns res_i when accept && write_back_en_i && rd_i!=0 && rsN_addr==rd_i, i.e. same-cycle forwarding. Read latency of a write becomes 0.
- Undefined: read ports return register-array contents only. The new value appears the cycle after the write edge.
- x0 rule holds in both builds.

Decomposition:
- Shared package wb_pkg: XLEN/NREGS constants; state enum (IDLE, REDIRECT, FLUSH); REG_ZERO=5'd0.
- One natural sub-module: regfile_2r1w (32xXLEN, two combinational read ports, one synchronous write port, x0 forced zero, bypass under WB_BYPASS_EN).
- FSM, redirect and retire logic live in write_back_stage.

Test Plan:
- Reset then write: RST_N low 2 cycles, then x5<=64'hDEAD_BEEF. Required: all reads 0 after reset; rs1_addr=5 returns DEAD_BEEF next cycle; retire_count=1.
- x0 write: rd_i=0, res_i=64'hFFFF, write_back_en_i=1. Required: rs1_data for addr 0 stays 0; retire_count still increments.
- Taken branch: PC_i=64'h1000, branch_offset_i=64'hFFFF_FFFF_FFFF_FFF0, FLUSH_CYCLES=2. Required: redirect_valid pulses 1 cycle with redirect_pc=64'h0FF0; flush high 3 cycles; writes to x7 during the flush window are not committed and not retired.
- Link write plus branch: take_branch_i=1, write_back_en_i=1, rd_i=1, res_i=64'h1004. Required: x1=64'h1004 and the redirect is issued.
- Reset mid-flush: assert RST_N low in the FLUSH state. Required: flush=0 the next cycle, state IDLE, retire_count=0, and the next valid instruction is accepted immediately.
- Bypass: with WB_BYPASS_EN, write x3=7 while rs2_addr=3. Required: rs2_data=7 in the same cycle. Without the macro: old value that cycle, 7 the next.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
// Holds the datapath/register-file sizes, the FSM state type and the x0 index.
package wb_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 3;   // holds FLUSH_CYCLES up to 7

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StFlush
  } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: NREGS x XLEN, two combinational read ports and one
// synchronous write port. x0 always reads zero and ignores writes.
// Optional macro WB_BYPASS_EN: a read port that addresses the register being
// written this cycle returns the write data (same-cycle forwarding).
//
// Ports:
//   CLK, RST_N          clock and synchronous active-low reset (clears all regs)
//   we_i/waddr_i/wdata_i write port
//   raddr1_i/rdata1_o   read port 1
//   raddr2_i/rdata2_o   read port 2
module regfile_2r1w
  import wb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
`ifdef WB_BYPASS_EN
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
`endif
    // x0 masking last so neither storage nor bypass can leak through
    if (raddr1_i == REG_ZERO) rdata1_o = '0;
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
`ifdef WB_BYPASS_EN
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
`endif
    if (raddr2_i == REG_ZERO) rdata2_o = '0;
  end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: commits results to the register file, serves the two
// decode read ports, turns a taken branch into a one-cycle redirect followed
// by a flush window that squashes wrong-path instructions, and counts
// retired instructions.
// Optional macro WB_BYPASS_EN: same-cycle forwarding of the write data to the
// read ports (see regfile_2r1w).
//
// Ports:
//   CLK, RST_N                synchronous active-low reset
//   instr_valid_i, rd_i, res_i, write_back_en_i   write-back request
//   take_branch_i, branch_offset_i, PC_i          branch resolution
//   rs1_addr/rs1_data, rs2_addr/rs2_data          combinational read ports
//   redirect_valid, redirect_pc                   fetch redirect (1-cycle pulse)
//   flush                                         upstream squash window
//   retire_count                                  retired-instruction counter
module write_back_stage
  import wb_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              instr_valid_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   res_i,
  input  logic              write_back_en_i,
  input  logic              take_branch_i,
  input  logic [XLEN-1:0]   branch_offset_i,
  input  logic [XLEN-1:0]   PC_i,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic [XLEN-1:0]   retire_count
);

  wb_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic             flush_q;
  logic [XLEN-1:0]  retire_q;

  logic accept;
  logic rf_we;

  // Anything arriving outside IDLE is on the wrong path and is dropped.
  assign accept = instr_valid_i && (state_q == StIdle);
  assign rf_we  = accept && write_back_en_i && (rd_i != REG_ZERO);

  regfile_2r1w u_regfile (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .we_i     (rf_we),
    .waddr_i  (rd_i),
    .wdata_i  (res_i),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      retire_q         <= '0;
    end else begin
      if (accept) retire_q <= retire_q + XLEN'(1);
      unique case (state_q)
        StIdle: begin
          if (accept && take_branch_i) begin
            state_q          <= StRedirect;
            redirect_pc_q    <= PC_i + branch_offset_i;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            cnt_q            <= CNT_W'(FLUSH_CYCLES);
          end
        end
        StRedirect: begin
          redirect_valid_q <= 1'b0;
          state_q          <= StFlush;
        end
        StFlush: begin
          // Counter is loaded with FLUSH_CYCLES; leaving at 1 gives exactly
          // 1 + FLUSH_CYCLES cycles of flush including the redirect cycle.
          if (cnt_q == CNT_W'(1)) begin
            flush_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

  logic        CLK;
  logic        RST_N;
  logic        instr_valid_i;
  logic [4:0]  rd_i;
  logic [63:0] res_i;
  logic        write_back_en_i;
  logic        take_branch_i;
  logic [63:0] branch_offset_i;
  logic [63:0] PC_i;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [63:0] retire_count;

  int checks;
  int errors;

  write_back_stage #(.FLUSH_CYCLES(2)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .instr_valid_i   (instr_valid_i),
    .rd_i            (rd_i),
    .res_i           (res_i),
    .write_back_en_i (write_back_en_i),
    .take_branch_i   (take_branch_i),
    .branch_offset_i (branch_offset_i),
    .PC_i            (PC_i),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .retire_count    (retire_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_valid_i   = 1'b0;
    write_back_en_i = 1'b0;
    take_branch_i   = 1'b0;
  endtask

  initial begin
    logic [63:0] bypass_exp;
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    idle_inputs();
    rd_i = 5'd0; res_i = '0; branch_offset_i = '0; PC_i = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd7;

    // Reset for two cycles
    step();
    step();
    check("rst_flush", {63'd0, flush}, 64'd0);
    check("rst_redir_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_redir_pc", redirect_pc, 64'd0);
    check("rst_retire", retire_count, 64'd0);
    check("rst_x5", rs1_data, 64'd0);
    check("rst_x7", rs2_data, 64'd0);
    RST_N = 1'b1;

    // x5 <= DEAD_BEEF
    instr_valid_i = 1'b1; write_back_en_i = 1'b1; rd_i = 5'd5; res_i = 64'hDEAD_BEEF;
    step();
    idle_inputs();
    check("wr_x5", rs1_data, 64'hDEAD_BEEF);
    check("wr_retire", retire_count, 64'd1);

    // x0 write dropped, still retired
    rs1_addr = 5'd0;
    instr_valid_i = 1'b1; write_back_en_i = 1'b1; rd_i = 5'd0; res_i = 64'hFFFF;
    #1;
    check("x0_same_cycle", rs1_data, 64'd0);
    step();
    idle_inputs();
    check("x0_after", rs1_data, 64'd0);
    check("x0_retire", retire_count, 64'd2);

    // Taken branch 0x1000 + (-16) = 0x0FF0
    instr_valid_i = 1'b1; take_branch_i = 1'b1; write_back_en_i = 1'b0;
    PC_i = 64'h1000; branch_offset_i = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    check("br_redir_valid", {63'd0, redirect_valid}, 64'd1);
    check("br_redir_pc", redirect_pc, 64'h0FF0);
    check("br_flush0", {63'd0, flush}, 64'd1);
    check("br_retire", retire_count, 64'd3);
    // Wrong-path: a write to x7 that is also a taken branch
    instr_valid_i = 1'b1; take_branch_i = 1'b1; write_back_en_i = 1'b1;
    rd_i = 5'd7; res_i = 64'h77; PC_i = 64'h5000; branch_offset_i = 64'h10;
    step();
    check("br_redir_pulse", {63'd0, redirect_valid}, 64'd0);
    check("br_pc_hold", redirect_pc, 64'h0FF0);
    check("br_flush1", {63'd0, flush}, 64'd1);
    step();
    check("br_no_second_redir", {63'd0, redirect_valid}, 64'd0);
    check("br_flush2", {63'd0, flush}, 64'd1);
    step();
    check("br_flush_end", {63'd0, flush}, 64'd0);
    check("br_squash_retire", retire_count, 64'd3);
    check("br_squash_x7", rs2_data, 64'd0);
    check("br_pc_hold2", redirect_pc, 64'h0FF0);

    // First instruction after the flush is accepted
    take_branch_i = 1'b0; instr_valid_i = 1'b1; write_back_en_i = 1'b1;
    rd_i = 5'd9; res_i = 64'h55; rs1_addr = 5'd9;
    step();
    idle_inputs();
    check("post_flush_x9", rs1_data, 64'h55);
    check("post_flush_retire", retire_count, 64'd4);

    // Link write plus branch: 0x2000 + 8
    instr_valid_i = 1'b1; take_branch_i = 1'b1; write_back_en_i = 1'b1;
    rd_i = 5'd1; res_i = 64'h1004; PC_i = 64'h2000; branch_offset_i = 64'h8;
    rs1_addr = 5'd1;
    step();
    idle_inputs();
    check("link_x1", rs1_data, 64'h1004);
    check("link_redir_valid", {63'd0, redirect_valid}, 64'd1);
    check("link_redir_pc", redirect_pc, 64'h2008);
    check("link_retire", retire_count, 64'd5);
    step();
    step();
    check("mid_flush_high", {63'd0, flush}, 64'd1);

    // Reset in the FLUSH state
    RST_N = 1'b0;
    step();
    check("mf_rst_flush", {63'd0, flush}, 64'd0);
    check("mf_rst_retire", retire_count, 64'd0);
    check("mf_rst_redir_pc", redirect_pc, 64'd0);
    check("mf_rst_x1", rs1_data, 64'd0);
    RST_N = 1'b1;

    // Immediate accept after reset, plus bypass behaviour on x3
    instr_valid_i = 1'b1; write_back_en_i = 1'b1; rd_i = 5'd3; res_i = 64'd7;
    rs2_addr = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    bypass_exp = 64'd7;
`else
    bypass_exp = 64'd0;
`endif
    check("bypass_same_cycle", rs2_data, bypass_exp);
    step();
    idle_inputs();
    check("bypass_next_cycle", rs2_data, 64'd7);
    check("post_rst_retire", retire_count, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
